lut3_gate_array: RTL and testbench

//  Parametrised successor to the fixed 3-input logic gate: CHANNELS independent 3-input

---
 rtl/lut3_pkg.sv | 25 ++
 rtl/lut3_bitslice.sv | 23 ++
 rtl/lut3_gate_array.sv | 126 ++++++++++++
 tb/tb_lut3_gate_array.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lut3_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// lut3_pkg : truth-table constants and per-channel reset tables
// rev 1.0
// ---------------------------------------------------------------
package lut3_pkg;

  localparam logic [7:0] TT_AND  = 8'h80;
  localparam logic [7:0] TT_OR   = 8'hFE;
  localparam logic [7:0] TT_XOR3 = 8'h96;
  localparam logic [7:0] TT_MAJ  = 8'hE8;
  localparam logic [7:0] TT_ZERO = 8'h00;

  function automatic logic [7:0] default_tt(input int k);
    case (k)
      0:       default_tt = TT_AND;
      1:       default_tt = TT_OR;
      2:       default_tt = TT_XOR3;
      3:       default_tt = TT_MAJ;
      default: default_tt = TT_ZERO;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut3_bitslice.sv
`default_nettype none
// ---------------------------------------------------------------
// lut3_bitslice : WIDTH-bit 3-input gate, y[i] = tt[{a[i],b[i],c[i]}]
// rev 1.0
// ---------------------------------------------------------------
module lut3_bitslice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [7:0]       tt,
  output logic [WIDTH-1:0] y
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign y[i] = tt[{a[i], b[i], c[i]}];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/lut3_gate_array.sv
`default_nettype none
// ---------------------------------------------------------------
// lut3_gate_array : CHANNELS programmable 3-input gates, 2-stage valid/ready pipe
// rev 1.0
// ---------------------------------------------------------------
module lut3_gate_array
  import lut3_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          port_a,
  input  logic [WIDTH-1:0]          port_b,
  input  logic [WIDTH-1:0]          port_c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] rslt,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [3:0]                cfg_chan,
  input  logic [7:0]                cfg_table,
  output logic                      cfg_err,
  output logic [CNT_W-1:0]          rslt_count
);

  logic                      s1_valid;
  logic                      s2_valid;
  logic [WIDTH-1:0]          s1_a;
  logic [WIDTH-1:0]          s1_b;
  logic [WIDTH-1:0]          s1_c;
  logic [7:0]                tt [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] eval;

  logic s2_load;
  logic s1_load;
  logic cfg_fire;
  logic cfg_hit;
  logic in_fire;
  logic out_fire;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  // Tables only change with the pipe empty, so each result sees one table set.
  assign cfg_ready = !s1_valid && !s2_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_hit   = 32'(cfg_chan) < CHANNELS;
  assign in_ready  = s1_load && !cfg_fire;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_a <= port_a;
        s1_b <= port_b;
        s1_c <= port_c;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s2_valid <= 1'b0;
      rslt     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        rslt <= eval;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        tt[k] <= default_tt(k);
      end
      cfg_err <= 1'b0;
    end else if (cfg_fire) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (32'(cfg_chan) == k) begin
          tt[k] <= cfg_table;
        end
      end
      if (!cfg_hit) begin
        cfg_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rslt_count <= '0;
    end else if (out_fire) begin
      rslt_count <= rslt_count + CNT_W'(1);
    end
  end

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      lut3_bitslice #(
        .WIDTH (WIDTH)
      ) u_slice (
        .a  (s1_a),
        .b  (s1_b),
        .c  (s1_c),
        .tt (tt[k]),
        .y  (eval[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lut3_gate_array.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_lut3_gate_array : directed vectors, scoreboard queue + output monitor
// rev 1.0
// ---------------------------------------------------------------
module tb_lut3_gate_array;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  port_a, port_b, port_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rslt;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_chan;
  logic [7:0]  cfg_table;
  logic        cfg_err;
  logic [15:0] rslt_count;

  logic        rst4, in_valid4, in_ready4, out_valid4, cfg_ready4, cfg_err4;
  logic [31:0] rslt4;
  logic [3:0]  count4;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  lut3_gate_array #(.WIDTH(8), .CHANNELS(4), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready),
    .port_a(port_a), .port_b(port_b), .port_c(port_c), .out_valid(out_valid),
    .out_ready(out_ready), .rslt(rslt), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_table(cfg_table), .cfg_err(cfg_err), .rslt_count(rslt_count)
  );

  lut3_gate_array #(.WIDTH(8), .CHANNELS(4), .CNT_W(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .port_a(port_a), .port_b(port_b), .port_c(port_c), .out_valid(out_valid4),
    .out_ready(1'b1), .rslt(rslt4), .cfg_valid(1'b0), .cfg_ready(cfg_ready4),
    .cfg_chan(4'd0), .cfg_table(8'h00), .cfg_err(cfg_err4), .rslt_count(count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every delivered result is matched against the oldest expectation.
  always @(negedge sys_clk) begin
    if (!sys_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", rslt, 32'hxxxxxxxx);
      end else begin
        check("result", rslt, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] a, b, c, input logic [31:0] exp);
    int t;
    port_a = a; port_b = b; port_c = c; in_valid = 1'b1;
    t = 0;
    @(negedge sys_clk);
    while (!in_ready && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    else exp_q.push_back(exp);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [7:0] tbl);
    int t;
    cfg_chan = ch; cfg_table = tbl; cfg_valid = 1'b1;
    t = 0;
    @(negedge sys_clk);
    while (!cfg_ready && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    if (!cfg_ready) check("cfg_timeout", 32'd0, 32'd1);
    @(posedge sys_clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge sys_clk); #1;
      t++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; rst4 = 1'b1;
    in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
    cfg_valid = 1'b0; cfg_chan = 4'd0; cfg_table = 8'h00;
    port_a = 8'h00; port_b = 8'h00; port_c = 8'h00;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0; rst4 = 1'b0;

    @(negedge sys_clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_rslt", rslt, 32'd0);
    check("reset_count", 32'(rslt_count), 32'd0);
    check("reset_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge sys_clk); #1;

    // Test 1: default tables, latency 2, then cfg request while in flight
    port_a = 8'hF0; port_b = 8'hCC; port_c = 8'hAA; in_valid = 1'b1;
    @(negedge sys_clk);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(32'hE896FE80);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    cfg_chan = 4'd1; cfg_table = 8'h01; cfg_valid = 1'b1;
    @(negedge sys_clk);
    check("t1_out_valid_n1", 32'(out_valid), 32'd0);
    check("t2_cfg_ready_inflight", 32'(cfg_ready), 32'd0);
    @(negedge sys_clk);
    check("t1_out_valid_n2", 32'(out_valid), 32'd1);
    check("t2_cfg_ready_still_busy", 32'(cfg_ready), 32'd0);
    cfg_write(4'd1, 8'h01);
    check("t1_count", 32'(rslt_count), 32'd1);

    // Test 2: NOR3 on ch1
    send(8'hF0, 8'hCC, 8'hAA, 32'hE8960180);
    drain();

    // Test 3: backpressure, 4 samples
    out_ready = 1'b0;
    fork
      begin
        send(8'hFF, 8'h00, 8'h00, 32'h00FF0000);
        send(8'hFF, 8'hFF, 8'h00, 32'hFF000000);
        send(8'h00, 8'h00, 8'h00, 32'h0000FF00);
        send(8'hFF, 8'hFF, 8'hFF, 32'hFFFF00FF);
      end
    join_none
    repeat (6) @(posedge sys_clk);
    @(negedge sys_clk);
    check("t3_in_ready_stall", 32'(in_ready), 32'd0);
    check("t3_out_valid_hold", 32'(out_valid), 32'd1);
    check("t3_rslt_hold", rslt, 32'h00FF0000);
    check("t3_count_stall", 32'(rslt_count), 32'd2);
    @(posedge sys_clk); #1;
    out_ready = 1'b1;
    wait fork;
    drain();
    check("t3_count_after", 32'(rslt_count), 32'd6);

    // Test 4: simultaneous cfg and operand on empty pipe
    repeat (2) @(posedge sys_clk);
    #1;
    port_a = 8'hF0; port_b = 8'hCC; port_c = 8'hAA; in_valid = 1'b1;
    cfg_chan = 4'd0; cfg_table = 8'hFF; cfg_valid = 1'b1;
    @(negedge sys_clk);
    check("t4_cfg_ready", 32'(cfg_ready), 32'd1);
    check("t4_in_ready_blocked", 32'(in_ready), 32'd0);
    @(posedge sys_clk); #1;
    cfg_valid = 1'b0;
    @(negedge sys_clk);
    check("t4_in_ready_next", 32'(in_ready), 32'd1);
    exp_q.push_back(32'hE89601FF);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    drain();

    // Test 5: out-of-range channel
    cfg_write(4'd9, 8'h00);
    @(negedge sys_clk);
    check("t5_cfg_err", 32'(cfg_err), 32'd1);
    @(posedge sys_clk); #1;
    send(8'hF0, 8'hCC, 8'hAA, 32'hE89601FF);
    drain();
    check("t5_cfg_err_sticky", 32'(cfg_err), 32'd1);

    // Test 6: reset with both stages full
    out_ready = 1'b0;
    send(8'hFF, 8'h00, 8'h00, 32'h0);
    send(8'h00, 8'h00, 8'h00, 32'h0);
    exp_q.delete();
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_count", 32'(rslt_count), 32'd0);
    check("t6_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge sys_clk); #1;
    out_ready = 1'b1;
    send(8'hF0, 8'hCC, 8'hAA, 32'hE896FE80);
    drain();

    // Test 6b: 4-bit counter wraps after 17 results
    begin
      int acc;
      int t;
      acc = 0; t = 0;
      port_a = 8'hF0; port_b = 8'hCC; port_c = 8'hAA;
      in_valid4 = 1'b1;
      while (acc < 17 && t < 200) begin
        @(negedge sys_clk);
        if (in_ready4) acc++;
        @(posedge sys_clk); #1;
        t++;
      end
      in_valid4 = 1'b0;
      check("t6_wrap_accepted", 32'(acc), 32'd17);
      repeat (4) @(posedge sys_clk);
      @(negedge sys_clk);
      check("t6_wrap_count", 32'(count4), 32'd1);
      check("t6_wrap_rslt", rslt4, 32'hE896FE80);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
